// File: rtl/pwm_tone_pkg.sv
// Shared widths, FSM state type and timing helper for the PWM tone decoder.
package pwm_tone_pkg;

  localparam int PER_W  = 20;
  localparam int DUR_W  = 8;
  localparam int FRAC_W = 23;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    TONE
  } state_t;

  // clk cycles in one eighth of a second for a clock of clk_mhz MHz
  function automatic int eighth(input int clk_mhz);
    return clk_mhz * 1_000_000 / 8;
  endfunction

endpackage

// File: rtl/tone_edge_sync.sv
// 2-FF synchronizer for an asynchronous tone line with rise/fall pulse outputs.
// Both pulses see the same pipeline depth, so measured intervals are unbiased.
module tone_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/pwm_tone_decoder.sv
// Recovers notes (period, high time, duration in eighth-seconds) from a PWM tone line.
// One registered note_valid pulse per note, 1 clk after the deciding rise or silence timeout.
module pwm_tone_decoder
  import pwm_tone_pkg::*;
#(
  parameter int CLK_FRE     = 50,
  parameter int TOL_SHIFT   = 4,
  parameter int SILENCE_CYC = 1_000_000,
  parameter int EIGHTH_CYC  = eighth(CLK_FRE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  output logic             note_valid,
  output logic [PER_W-1:0] note_period,
  output logic [PER_W-1:0] note_high,
  output logic [DUR_W-1:0] note_eighths,
  output logic             tone_active
);

  localparam logic [FRAC_W-1:0] EIGHTH  = FRAC_W'(EIGHTH_CYC);
  localparam logic [FRAC_W-1:0] HALF    = FRAC_W'(EIGHTH_CYC / 2);
  localparam logic [PER_W-1:0]  SILENCE = PER_W'(SILENCE_CYC);
  localparam logic [PER_W-1:0]  PER_MAX = '1;
  localparam logic [DUR_W-1:0]  DUR_MAX = '1;

  logic rise, fall;

  tone_edge_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(tone_in),
    .rise_o (rise),
    .fall_o (fall)
  );

  state_t            state_q, state_d;
  logic [PER_W-1:0]  per_q, hi_q, hi_snap_q, hi_last_q, ref_q;
  logic              hi_run_q;
  logic [FRAC_W-1:0] frac_q, dsnap_frac_q;
  logic [DUR_W-1:0]  whole_q, dsnap_whole_q;

  logic              new_note, take_snap, emit_chg, emit_fin;
  logic [PER_W-1:0]  diff;
  logic              same, timeout, carry;
  logic [FRAC_W-1:0] start_frac;
  logic [DUR_W:0]    fin_sum;
  logic [DUR_W-1:0]  fin_eighths;

  always_comb begin
    diff        = (per_q >= ref_q) ? (per_q - ref_q) : (ref_q - per_q);
    same        = diff <= (ref_q >> TOL_SHIFT);
    timeout     = (per_q == SILENCE) && !rise;
    // The note began one period ago, so that period is already on the clock.
    start_frac  = HALF + FRAC_W'(per_q);
    carry       = ({1'b0, dsnap_frac_q} + (FRAC_W+1)'(ref_q)) >= {1'b0, EIGHTH};
    fin_sum     = {1'b0, dsnap_whole_q} + {{DUR_W{1'b0}}, carry};
    fin_eighths = fin_sum[DUR_W] ? DUR_MAX : fin_sum[DUR_W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    new_note  = 1'b0;
    take_snap = 1'b0;
    emit_chg  = 1'b0;
    emit_fin  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) state_d = ACQUIRE;
      end
      ACQUIRE: begin
        if (rise) begin
          state_d  = TONE;
          new_note = 1'b1;
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      TONE: begin
        if (rise) begin
          if (same) begin
            take_snap = 1'b1;
          end else begin
            emit_chg = 1'b1;
            new_note = 1'b1;
          end
        end else if (timeout) begin
          emit_fin = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      per_q         <= '0;
      hi_q          <= '0;
      hi_run_q      <= 1'b0;
      hi_snap_q     <= '0;
      hi_last_q     <= '0;
      ref_q         <= '0;
      frac_q        <= '0;
      whole_q       <= '0;
      dsnap_frac_q  <= '0;
      dsnap_whole_q <= '0;
      note_valid    <= 1'b0;
      note_period   <= '0;
      note_high     <= '0;
      note_eighths  <= '0;
    end else begin
      state_q <= state_d;

      // The rise cycle itself is the first cycle of both the period and the high time.
      if (rise) begin
        per_q     <= 1;
        hi_q      <= 1;
        hi_run_q  <= 1'b1;
        hi_snap_q <= hi_q;
        hi_last_q <= hi_snap_q;
      end else begin
        if (per_q != PER_MAX) per_q <= per_q + 1'b1;
        if (fall) hi_run_q <= 1'b0;
        else if (hi_run_q && hi_q != PER_MAX) hi_q <= hi_q + 1'b1;
      end

      if (new_note) begin
        ref_q   <= per_q;
        frac_q  <= start_frac;
        whole_q <= '0;
      end else if (frac_q == EIGHTH - 1'b1) begin
        frac_q <= '0;
        if (whole_q != DUR_MAX) whole_q <= whole_q + 1'b1;
      end else begin
        frac_q <= frac_q + 1'b1;
      end

      // At a note start the snapshot is what the counter reads had it run since the note began.
      if (new_note) begin
        dsnap_frac_q  <= start_frac - 1'b1;
        dsnap_whole_q <= '0;
      end else if (take_snap) begin
        dsnap_frac_q  <= frac_q;
        dsnap_whole_q <= whole_q;
      end

      note_valid <= emit_chg | emit_fin;
      if (emit_chg) begin
        note_period  <= ref_q;
        note_high    <= hi_last_q;
        note_eighths <= dsnap_whole_q;
      end else if (emit_fin) begin
        note_period  <= ref_q;
        note_high    <= hi_snap_q;
        note_eighths <= fin_eighths;
      end
    end
  end

  assign tone_active = (state_q == TONE);

endmodule
